// File: rtl/int_to_float.sv
// Signed 32-bit integer to IEEE-754 single-precision converter, round-to-nearest-even.
// Multi-cycle FSM with strobe/acknowledge handshakes on both the input and output channels.
module int_to_float (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  localparam logic [2:0] S_GET_A     = 3'd0;
  localparam logic [2:0] S_CONVERT_0 = 3'd1;
  localparam logic [2:0] S_NORMALISE = 3'd2;
  localparam logic [2:0] S_CONVERT_1 = 3'd3;
  localparam logic [2:0] S_ROUND     = 3'd4;
  localparam logic [2:0] S_PACK      = 3'd5;
  localparam logic [2:0] S_PUT_Z     = 3'd6;

  logic [2:0]  r_state;
  logic [31:0] r_a;
  logic [31:0] r_value;
  logic [9:0]  r_zExp;
  logic [23:0] r_zMant;
  logic        r_zSign;
  logic        r_guard;
  logic        r_roundBit;
  logic        r_sticky;
  logic [31:0] r_z;
  logic        r_inputAck;
  logic [31:0] r_outputZ;
  logic        r_outputStb;

  logic [31:0] w_absA;
  logic        w_roundUp;

  // Negation wraps modulo 2^32, so -2^31 maps onto 0x80000000 unsigned.
  assign w_absA    = r_a[31] ? (~r_a + 32'd1) : r_a;
  assign w_roundUp = r_guard & (r_roundBit | r_sticky | r_zMant[0]);

  assign input_a_ack  = r_inputAck;
  assign output_z     = r_outputZ;
  assign output_z_stb = r_outputStb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_GET_A;
      r_a         <= 32'd0;
      r_value     <= 32'd0;
      r_zExp      <= 10'd0;
      r_zMant     <= 24'd0;
      r_zSign     <= 1'b0;
      r_guard     <= 1'b0;
      r_roundBit  <= 1'b0;
      r_sticky    <= 1'b0;
      r_z         <= 32'd0;
      r_inputAck  <= 1'b0;
      r_outputZ   <= 32'd0;
      r_outputStb <= 1'b0;
    end else begin
      case (r_state)
        S_GET_A: begin
          r_inputAck <= 1'b1;
          if (r_inputAck && input_a_stb) begin
            r_a        <= input_a;
            r_inputAck <= 1'b0;
            r_state    <= S_CONVERT_0;
          end
        end

        S_CONVERT_0: begin
          if (r_a == 32'd0) begin
            r_z     <= 32'd0;
            r_state <= S_PUT_Z;
          end else begin
            r_zSign <= r_a[31];
            r_value <= w_absA;
            r_zExp  <= 10'sd31;
            r_state <= S_NORMALISE;
          end
        end

        // One bit of left shift per cycle until the leading one reaches bit 31.
        S_NORMALISE: begin
          if (r_value[31]) begin
            r_state <= S_CONVERT_1;
          end else begin
            r_value <= {r_value[30:0], 1'b0};
            r_zExp  <= r_zExp - 10'd1;
          end
        end

        S_CONVERT_1: begin
          r_zMant    <= r_value[31:8];
          r_guard    <= r_value[7];
          r_roundBit <= r_value[6];
          r_sticky   <= |r_value[5:0];
          r_state    <= S_ROUND;
        end

        S_ROUND: begin
          if (w_roundUp) begin
            r_zMant <= r_zMant + 24'd1;
            if (r_zMant == 24'hFFFFFF) begin
              r_zExp <= r_zExp + 10'd1;
            end
          end
          r_state <= S_PACK;
        end

        // Exponent is always 0..31 here, so no overflow or denormal handling is needed.
        S_PACK: begin
          r_z     <= {r_zSign, r_zExp[7:0] + 8'd127, r_zMant[22:0]};
          r_state <= S_PUT_Z;
        end

        S_PUT_Z: begin
          r_outputStb <= 1'b1;
          r_outputZ   <= r_z;
          if (r_outputStb && output_z_ack) begin
            r_outputStb <= 1'b0;
            r_state     <= S_GET_A;
          end
        end

        default: begin
          r_state <= S_GET_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_float.sv
// Scoreboard bench for int_to_float: a driver queues expected results with latencies and
// a separate monitor pops and checks them whenever the converter presents an output.
module tb_int_to_float;

  logic        clk;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  typedef struct {
    logic [31:0] expZ;
    int          expLat;
    int          hold;
  } expT;

  expT scoreboard[$];
  int  testsRun;
  int  failCount;
  int  cycleCount;
  int  acceptCycle;
  bit  monitorBusy;

  int_to_float dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycleCount = 0;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Queue the expected response (if tracked), then hold the strobe until the converter takes the operand.
  task automatic applyStimulus(input logic [31:0] value, input logic [31:0] expZ, input int expLat,
                               input int hold, input bit track);
    int waited;
    expT item;
    if (track) begin
      item.expZ   = expZ;
      item.expLat = expLat;
      item.hold   = hold;
      scoreboard.push_back(item);
    end
    @(negedge clk);
    input_a     = value;
    input_a_stb = 1'b1;
    waited      = 0;
    while (!input_a_ack && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!input_a_ack) begin
      checkOutput("acceptTimeout", 32'd0, 32'd1);
      input_a_stb = 1'b0;
      return;
    end
    acceptCycle = cycleCount + 1;
    @(negedge clk);
    input_a_stb = 1'b0;
    input_a     = 32'hDEADBEEF;
  endtask

  task automatic drainScoreboard();
    int waited;
    waited = 0;
    while ((scoreboard.size() != 0 || monitorBusy) && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (scoreboard.size() != 0 || monitorBusy) begin
      checkOutput("drainTimeout", 32'd0, 32'd1);
    end
  endtask

  // Monitor: on each rising output strobe, pop and compare, apply backpressure, then acknowledge.
  initial begin
    logic [31:0] seen;
    int          riseLat;
    int          hold;
    expT         item;
    output_z_ack = 1'b0;
    monitorBusy  = 1'b0;
    forever begin
      @(negedge clk);
      if (output_z_stb && !rst) begin
        monitorBusy = 1'b1;
        seen        = output_z;
        riseLat     = cycleCount - acceptCycle;
        hold        = 0;
        if (scoreboard.size() == 0) begin
          checkOutput("unexpectedOutput", 32'd1, 32'd0);
        end else begin
          item = scoreboard.pop_front();
          checkOutput("resultValue", seen, item.expZ);
          if (item.expLat >= 0) checkOutput("latency", riseLat, item.expLat);
          hold = item.hold;
        end
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          checkOutput("holdStb", {31'd0, output_z_stb}, 32'd1);
          checkOutput("holdValue", output_z, seen);
          checkOutput("holdInAck", {31'd0, input_a_ack}, 32'd0);
        end
        output_z_ack = 1'b1;
        @(negedge clk);
        output_z_ack = 1'b0;
        checkOutput("stbDrop", {31'd0, output_z_stb}, 32'd0);
        checkOutput("inAckLowAfterXfer", {31'd0, input_a_ack}, 32'd0);
        @(negedge clk);
        checkOutput("inAckRise", {31'd0, input_a_ack}, 32'd1);
        monitorBusy = 1'b0;
      end
    end
  end

  initial begin
    testsRun    = 0;
    failCount   = 0;
    acceptCycle = 0;
    rst         = 1'b1;
    input_a     = 32'd0;
    input_a_stb = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetInAck", {31'd0, input_a_ack}, 32'd0);
    checkOutput("resetOutStb", {31'd0, output_z_stb}, 32'd0);
    checkOutput("resetOutZ", output_z, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("firstInAck", {31'd0, input_a_ack}, 32'd1);

    applyStimulus(32'd1,        32'h3F800000, 37, 5, 1'b1);
    applyStimulus(32'hFFFFFFFF, 32'hBF800000, 37, 0, 1'b1);
    applyStimulus(32'd0,        32'h00000000,  2, 0, 1'b1);
    applyStimulus(32'h7FFFFFFF, 32'h4F000000,  7, 0, 1'b1);
    applyStimulus(32'h80000000, 32'hCF000000,  6, 0, 1'b1);
    applyStimulus(32'd16777217, 32'h4B800000, 13, 0, 1'b1);
    applyStimulus(32'd16777219, 32'h4B800002, 13, 0, 1'b1);
    applyStimulus(-32'sd16777221, 32'hCB800002, 13, 0, 1'b1);
    applyStimulus(32'd3,        32'h40400000, 36, 0, 1'b1);
    applyStimulus(-32'sd7,      32'hC0E00000, 35, 0, 1'b1);
    applyStimulus(32'd100,      32'h42C80000, 31, 0, 1'b1);
    drainScoreboard();

    // Abort a long conversion mid-normalise; its result must never appear.
    applyStimulus(32'd1, 32'd0, -1, 0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abortInAck", {31'd0, input_a_ack}, 32'd0);
    checkOutput("abortOutStb", {31'd0, output_z_stb}, 32'd0);
    applyStimulus(32'd5, 32'h40A00000, 35, 0, 1'b1);
    drainScoreboard();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
